// File: rtl/sha256_round_engine.sv
// SHA-256 compression engine: ROUNDS_PER_CYCLE chained rounds per clock, 16-word W window.
// Optional feed-forward addition enabled by SHA256_ROUND_ENGINE_FEEDFORWARD_EN.
module sha256_round_engine #(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_start,
  input  logic [511:0] in_block,
  input  logic [255:0] in_hash,
  output logic         out_busy,
  output logic         out_done,
  output logic [255:0] out_hash
);

  typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] big_sig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] small_sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  state_e         state_q, state_d;
  logic [6:0]     cnt_q, cnt_d;
  logic [255:0]   hash_q, hash_d;
  logic [31:0]    wk_q [8];
  logic [31:0]    wk_d [8];
  logic [31:0]    w_q [16];
  logic [31:0]    w_d [16];
  logic [31:0]    rnd_wk [8];
  logic [31:0]    rnd_w [16];
  logic [255:0]   result;
  logic           accept;
  logic           last_round;
`ifdef SHA256_ROUND_ENGINE_FEEDFORWARD_EN
  logic [31:0]    ff_q [8];
  logic [31:0]    ff_d [8];
`endif

  assign accept     = in_start && (state_q == StIdle || state_q == StDone);
  assign last_round = (cnt_q == 7'(64 - ROUNDS_PER_CYCLE));

  // Chained rounds; W window slides one word per round, w[0] is always W[t].
  always_comb begin : p_rounds
    logic [31:0] v [8];
    logic [31:0] win [16];
    logic [31:0] t1, t2, nw;
    logic [5:0]  k_idx;
    v     = wk_q;
    win   = w_q;
    t1    = '0;
    t2    = '0;
    nw    = '0;
    k_idx = '0;
    for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
      k_idx = cnt_q[5:0] + 6'(i);
      t1 = v[7] + big_sig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[k_idx] + win[0];
      t2 = big_sig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      nw = small_sig1(win[14]) + win[9] + small_sig0(win[1]) + win[0];
      v[7] = v[6];
      v[6] = v[5];
      v[5] = v[4];
      v[4] = v[3] + t1;
      v[3] = v[2];
      v[2] = v[1];
      v[1] = v[0];
      v[0] = t1 + t2;
      for (int j = 0; j < 15; j++) win[j] = win[j + 1];
      win[15] = nw;
    end
    rnd_wk = v;
    rnd_w  = win;
  end

  always_comb begin
    result = '0;
    for (int i = 0; i < 8; i++) begin
`ifdef SHA256_ROUND_ENGINE_FEEDFORWARD_EN
      result[255 - 32 * i -: 32] = rnd_wk[i] + ff_q[i];
`else
      result[255 - 32 * i -: 32] = rnd_wk[i];
`endif
    end
  end

  always_comb begin
    wk_d   = wk_q;
    w_d    = w_q;
    cnt_d  = cnt_q;
    hash_d = hash_q;
`ifdef SHA256_ROUND_ENGINE_FEEDFORWARD_EN
    ff_d   = ff_q;
`endif
    if (accept) begin
      for (int i = 0; i < 8; i++) begin
        wk_d[i] = in_hash[255 - 32 * i -: 32];
`ifdef SHA256_ROUND_ENGINE_FEEDFORWARD_EN
        ff_d[i] = in_hash[255 - 32 * i -: 32];
`endif
      end
      for (int i = 0; i < 16; i++) w_d[i] = in_block[511 - 32 * i -: 32];
      cnt_d = '0;
    end else if (state_q == StRound) begin
      wk_d  = rnd_wk;
      w_d   = rnd_w;
      cnt_d = cnt_q + 7'(ROUNDS_PER_CYCLE);
      if (last_round) hash_d = result;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_start) state_d = StRound;
      StRound: if (last_round) state_d = StDone;
      StDone:  state_d = in_start ? StRound : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hash_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hash_q  <= hash_d;
    end
  end

  // Datapath registers carry no reset; they are always loaded on acceptance.
  always_ff @(posedge clk) begin
    wk_q <= wk_d;
    w_q  <= w_d;
`ifdef SHA256_ROUND_ENGINE_FEEDFORWARD_EN
    ff_q <= ff_d;
`endif
  end

  always_comb begin
    out_busy = (state_q == StRound);
    out_done = (state_q == StDone);
    out_hash = hash_q;
  end

endmodule

// File: tb/tb_sha256_round_engine.sv
// Directed scoreboard bench for sha256_round_engine; one DUT per ROUNDS_PER_CYCLE value.
module tb_sha256_round_engine;

  localparam int NDUT = 5;
`ifdef SHA256_ROUND_ENGINE_FEEDFORWARD_EN
  localparam bit FF = 1'b1;
`else
  localparam bit FF = 1'b0;
`endif

  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] DIG_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] DIG_TWO =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_TWO1  = {
    256'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b,
    256'h696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000};
  localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};

  typedef struct {
    int           dut;
    logic [255:0] addend;
    logic [255:0] digest;
    bit           check;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [511:0] in_block;
  logic [255:0] in_hash;
  logic         start_v [NDUT];
  logic         busy_v  [NDUT];
  logic         done_v  [NDUT];
  logic [255:0] hash_v  [NDUT];

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    sha256_round_engine #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_start (start_v[g]),
      .in_block (in_block),
      .in_hash  (in_hash),
      .out_busy (busy_v[g]),
      .out_done (done_v[g]),
      .out_hash (hash_v[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] add_words(input logic [255:0] a, input logic [255:0] b);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32 * i +: 32] = a[32 * i +: 32] + b[32 * i +: 32];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    for (int i = 0; i < 16; i++) in_block[32 * i +: 32] = $urandom();
    for (int i = 0; i < 8; i++) in_hash[32 * i +: 32] = $urandom();
  endtask

  // Drive one start; the expected digest goes onto the scoreboard at drive time.
  task automatic start_blk(input int g, input logic [511:0] blk, input logic [255:0] h,
                           input logic [255:0] dig, input bit check, input bit sync);
    exp_t e;
    if (sync) @(negedge clk);
    in_block   = blk;
    in_hash    = h;
    start_v[g] = 1'b1;
    e.dut    = g;
    e.addend = FF ? 256'h0 : h;
    e.digest = dig;
    e.check  = check;
    sb_q.push_back(e);
    @(negedge clk);
    start_v[g] = 1'b0;
    scramble();
  endtask

  // n0 = edges already elapsed since in_start was raised.
  task automatic wait_done(input int g, input int lat, input int n0);
    int n;
    n = n0;
    while (!done_v[g] && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("latency_dut%0d", g), 256'(n), 256'(lat));
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < NDUT; g++) begin
      if (rst_n && done_v[g]) begin
        if (sb_q.size() == 0) begin
          chk($sformatf("unexpected_done_dut%0d", g), 256'(1), 256'(0));
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sb_dut_index", 256'(g), 256'(e.dut));
          if (e.check)
            chk($sformatf("sb_hash_dut%0d", g), add_words(hash_v[g], e.addend), e.digest);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] h1;
    int nd;
    rst_n    = 1'b0;
    in_block = '0;
    in_hash  = '0;
    for (int g = 0; g < NDUT; g++) start_v[g] = 1'b0;
    #1;
    for (int g = 0; g < NDUT; g++) begin
      chk($sformatf("reset_busy_dut%0d", g), 256'(busy_v[g]), 256'(0));
      chk($sformatf("reset_done_dut%0d", g), 256'(done_v[g]), 256'(0));
      chk($sformatf("reset_hash_dut%0d", g), hash_v[g], 256'h0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // "abc" single block
    start_blk(0, BLK_ABC, IV, DIG_ABC, 1'b1, 1'b1);
    chk("busy_in_round", 256'(busy_v[0]), 256'(1));
    wait_done(0, 65, 1);
    chk("busy_in_done", 256'(busy_v[0]), 256'(0));
    @(negedge clk);
    chk("done_single_pulse", 256'(done_v[0]), 256'(0));
    chk("hash_held", add_words(hash_v[0], FF ? 256'h0 : IV), DIG_ABC);

    // Empty string across every unroll factor
    for (int g = 0; g < NDUT; g++) begin
      start_blk(g, BLK_EMPTY, IV, DIG_EMPTY, 1'b1, 1'b1);
      wait_done(g, 64 / (1 << g) + 1, 1);
    end

    // Start pulse mid-ROUND must be ignored
    start_blk(0, BLK_ABC, IV, DIG_ABC, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    start_v[0] = 1'b1;
    scramble();
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0, 65, 12);

    // Two-block chaining, block 2 started in the DONE cycle of block 1
    @(negedge clk);
    start_blk(0, BLK_TWO1, IV, 256'h0, 1'b0, 1'b1);
    wait_done(0, 65, 1);
    chk("chain_busy_drop", 256'(busy_v[0]), 256'(0));
    h1 = FF ? hash_v[0] : add_words(hash_v[0], IV);
    start_blk(0, BLK_TWO2, h1, DIG_TWO, 1'b1, 1'b0);
    chk("chain_busy_back", 256'(busy_v[0]), 256'(1));
    wait_done(0, 65, 1);

    // in_start held high across DONE restarts immediately
    @(negedge clk);
    @(negedge clk);
    in_block   = BLK_EMPTY;
    in_hash    = IV;
    start_v[0] = 1'b1;
    sb_q.push_back('{dut: 0, addend: FF ? 256'h0 : IV, digest: DIG_EMPTY, check: 1'b1});
    sb_q.push_back('{dut: 0, addend: FF ? 256'h0 : IV, digest: DIG_EMPTY, check: 1'b1});
    @(negedge clk);
    wait_done(0, 65, 1);
    chk("hold_busy_done", 256'(busy_v[0]), 256'(0));
    @(negedge clk);
    chk("hold_restart", 256'(busy_v[0]), 256'(1));
    start_v[0] = 1'b0;
    wait_done(0, 65, 1);

    // Asynchronous reset at round 30 aborts the block
    start_blk(0, BLK_ABC, IV, DIG_ABC, 1'b1, 1'b1);
    repeat (30) @(negedge clk);
    #2;
    rst_n = 1'b0;
    void'(sb_q.pop_back());
    #1;
    chk("abort_busy", 256'(busy_v[0]), 256'(0));
    chk("abort_done", 256'(done_v[0]), 256'(0));
    chk("abort_hash", hash_v[0], 256'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (80) begin
      @(negedge clk);
      if (done_v[0]) nd++;
    end
    chk("no_done_after_abort", 256'(nd), 256'(0));

    // First start after reset is accepted normally
    start_blk(0, BLK_ABC, IV, DIG_ABC, 1'b1, 1'b0);
    wait_done(0, 65, 1);
    @(negedge clk);
    chk("scoreboard_drained", 256'(sb_q.size()), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
